ex_mem_pipe_reg: RTL

//  EX/MEM pipeline register with an NPU offload sequencer. Captures the flush-filtered EX control word and
//  the EX datapath results each cycle and presents them to the MEM stage. When EX issues an NPU op, it

---
 rtl/ex_mem_pipe_reg_if.sv | 40 ++++
 rtl/ex_mem_pipe_reg.sv | 119 +++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg_if.sv
// EX -> EX/MEM -> MEM signal bundle, including the NPU offload handshake.
// The master side drives the EX/NPU inputs; the slave side is the pipeline register.
interface ex_mem_pipe_reg_if #(
    parameter int XLEN = 32
);
    logic [4:0]      ex_f_ctrl;
    logic            ex_valid;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_rs2_data;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_pc_plus4;
    logic            ex_npu_op;
    logic            mem_hold;
    logic            npu_done;
    logic [XLEN-1:0] npu_result;

    logic [4:0]      mem_ctrl;
    logic            mem_valid;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_wdata;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_pc_plus4;
    logic            npu_start;
    logic            npu_stall;
    logic            npu_err;

    modport master (
        output ex_f_ctrl, ex_valid, ex_alu_result, ex_rs2_data, ex_rd, ex_pc_plus4,
               ex_npu_op, mem_hold, npu_done, npu_result,
        input  mem_ctrl, mem_valid, mem_alu_result, mem_wdata, mem_rd, mem_pc_plus4,
               npu_start, npu_stall, npu_err
    );

    modport slave (
        input  ex_f_ctrl, ex_valid, ex_alu_result, ex_rs2_data, ex_rd, ex_pc_plus4,
               ex_npu_op, mem_hold, npu_done, npu_result,
        output mem_ctrl, mem_valid, mem_alu_result, mem_wdata, mem_rd, mem_pc_plus4,
               npu_start, npu_stall, npu_err
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with an NPU offload sequencer (IDLE -> START -> WAIT).
// NPU ops park a bubble in MEM and deliver the NPU result once the NPU completes or times out.
module ex_mem_pipe_reg #(
    parameter int XLEN        = 32,
    parameter int NPU_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    ex_mem_pipe_reg_if.slave pipe_io
);
    localparam int CW = $clog2(NPU_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [4:0]      mem_ctrl_q;
    logic            mem_valid_q;
    logic [XLEN-1:0] mem_alu_result_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [4:0]      mem_rd_q;
    logic [XLEN-1:0] mem_pc_plus4_q;
    logic [4:0]      sh_ctrl_q;
    logic [4:0]      sh_rd_q;
    logic [XLEN-1:0] sh_pc_plus4_q;
    logic            npu_start_q;
    logic            npu_err_q;
    logic            npu_issue;
    logic            cnt_at_max;

    assign npu_issue  = pipe_io.ex_valid && pipe_io.ex_npu_op && !pipe_io.mem_hold;
    assign cnt_at_max = (cnt_q == CW'(NPU_TIMEOUT));
    // Saturating increment: the WAIT exit on timeout means it never really saturates.
    assign cnt_d      = cnt_at_max ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            mem_ctrl_q       <= '0;
            mem_valid_q      <= 1'b0;
            mem_alu_result_q <= '0;
            mem_wdata_q      <= '0;
            mem_rd_q         <= '0;
            mem_pc_plus4_q   <= '0;
            sh_ctrl_q        <= '0;
            sh_rd_q          <= '0;
            sh_pc_plus4_q    <= '0;
            npu_start_q      <= 1'b0;
            npu_err_q        <= 1'b0;
        end else begin
            npu_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (npu_issue) begin
                        sh_ctrl_q        <= pipe_io.ex_f_ctrl;
                        sh_rd_q          <= pipe_io.ex_rd;
                        sh_pc_plus4_q    <= pipe_io.ex_pc_plus4;
                        mem_ctrl_q       <= '0;
                        mem_valid_q      <= 1'b0;
                        mem_alu_result_q <= '0;
                        mem_wdata_q      <= '0;
                        mem_rd_q         <= '0;
                        mem_pc_plus4_q   <= '0;
                        npu_start_q      <= 1'b1;
                        state_q          <= S_START;
                    end else if (!pipe_io.mem_hold) begin
                        mem_ctrl_q       <= pipe_io.ex_f_ctrl;
                        mem_valid_q      <= pipe_io.ex_valid;
                        mem_alu_result_q <= pipe_io.ex_alu_result;
                        mem_wdata_q      <= pipe_io.ex_rs2_data;
                        mem_rd_q         <= pipe_io.ex_rd;
                        mem_pc_plus4_q   <= pipe_io.ex_pc_plus4;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // npu_done takes priority over a coinciding timeout.
                    if (pipe_io.npu_done) begin
                        mem_ctrl_q       <= sh_ctrl_q;
                        mem_valid_q      <= 1'b1;
                        mem_alu_result_q <= pipe_io.npu_result;
                        mem_wdata_q      <= '0;
                        mem_rd_q         <= sh_rd_q;
                        mem_pc_plus4_q   <= sh_pc_plus4_q;
                        state_q          <= S_IDLE;
                    end else if (cnt_at_max) begin
                        npu_err_q        <= 1'b1;
                        mem_ctrl_q       <= '0;
                        mem_valid_q      <= 1'b0;
                        mem_alu_result_q <= '0;
                        mem_wdata_q      <= '0;
                        mem_rd_q         <= '0;
                        mem_pc_plus4_q   <= '0;
                        state_q          <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pipe_io.mem_ctrl       = mem_ctrl_q;
    assign pipe_io.mem_valid      = mem_valid_q;
    assign pipe_io.mem_alu_result = mem_alu_result_q;
    assign pipe_io.mem_wdata      = mem_wdata_q;
    assign pipe_io.mem_rd         = mem_rd_q;
    assign pipe_io.mem_pc_plus4   = mem_pc_plus4_q;
    assign pipe_io.npu_start      = npu_start_q;
    assign pipe_io.npu_err        = npu_err_q;
    // Stall rises combinationally in the issue cycle so upstream freezes immediately.
    assign pipe_io.npu_stall      = (state_q != S_IDLE) || npu_issue;
endmodule
